match_controller: RTL

Top-level match sequencer for the pong game. Owns the match state machine (idle, serve countdown, play, pause, point freeze, game over) and both score counters. Gates the game-logic update strobes through `run_o`, requests a ball recenter through `serve_o`, and exports scores and winner to the renderer. Sits between the board key inputs / game logic and the sprite/score display path.

---
 rtl/match_pkg.sv | 21 ++
 rtl/match_controller_frame_timer.sv | 28 ++
 rtl/match_controller.sv | 132 +++++++++++++
 3 files changed

// File: rtl/match_pkg.sv
// rtl/match_pkg.sv - shared types and defaults for the pong match sequencer
package match_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_POINT     = 3'd4,
        ST_GAME_OVER = 3'd5
    } match_state_t;

    localparam logic [1:0] WINNER_NONE   = 2'b00;
    localparam logic [1:0] WINNER_PLAYER = 2'b01;
    localparam logic [1:0] WINNER_ENEMY  = 2'b10;

    localparam int DEF_WIN_SCORE    = 7;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_POINT_FRAMES = 90;

endpackage

// File: rtl/match_controller_frame_timer.sv
// rtl/match_controller_frame_timer.sv - clearable frame counter with limit compare
module frame_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             new_frame_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (new_frame_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Fires on the pulse that brings the count to the limit.
    assign expired_o = new_frame_i && (count_q == limit_i - 1'b1);

endmodule

// File: rtl/match_controller.sv
// rtl/match_controller.sv - pong match FSM, score counters and start-key edge detect
module match_controller
    import match_pkg::*;
#(
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int SCORE_W      = 4,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int POINT_FRAMES = DEF_POINT_FRAMES,
    parameter int FRAME_CNT_W  = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               new_frame_i,
    input  logic               miss_left_i,
    input  logic               miss_right_i,
    output logic               run_o,
    output logic               serve_o,
    output logic [SCORE_W-1:0] player_score_o,
    output logic [SCORE_W-1:0] enemy_score_o,
    output logic [1:0]         winner_o,
    output logic [2:0]         state_o
);

    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    match_state_t       state_q, state_d;
    logic               start_q, arm_q, press_q;
    logic               run_q, serve_q;
    logic [SCORE_W-1:0] player_q, player_d, enemy_q, enemy_d;
    logic [1:0]         winner_q, winner_d;
    logic               timing, timer_clear, timer_exp;
    logic [FRAME_CNT_W-1:0] timer_limit;

    assign timing      = (state_q == ST_SERVE) || (state_q == ST_POINT);
    assign timer_clear = (state_d != state_q);
    assign timer_limit = (state_q == ST_POINT) ? FRAME_CNT_W'(POINT_FRAMES)
                                               : FRAME_CNT_W'(SERVE_FRAMES);

    frame_timer #(.CNT_W(FRAME_CNT_W)) u_frame_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (timer_clear),
        .new_frame_i (new_frame_i && timing),
        .limit_i     (timer_limit),
        .expired_o   (timer_exp)
    );

    always_comb begin
        state_d  = state_q;
        player_d = player_q;
        enemy_d  = enemy_q;
        winner_d = winner_q;
        case (state_q)
            ST_IDLE: begin
                if (press_q) begin
                    state_d  = ST_SERVE;
                    player_d = '0;
                    enemy_d  = '0;
                end
            end
            ST_SERVE: begin
                if (timer_exp) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // A miss outranks a simultaneous press; a double miss scores nobody.
                if (miss_left_i || miss_right_i) begin
                    state_d = ST_POINT;
                    if (miss_left_i && !miss_right_i && player_q < WIN) player_d = player_q + 1'b1;
                    if (miss_right_i && !miss_left_i && enemy_q < WIN) enemy_d = enemy_q + 1'b1;
                end else if (press_q) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (press_q) state_d = ST_PLAY;
            end
            ST_POINT: begin
                if (timer_exp) begin
                    if (player_q == WIN || enemy_q == WIN) begin
                        state_d  = ST_GAME_OVER;
                        winner_d = (player_q == WIN) ? WINNER_PLAYER : WINNER_ENEMY;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end
            end
            ST_GAME_OVER: begin
                if (press_q) begin
                    state_d  = ST_SERVE;
                    player_d = '0;
                    enemy_d  = '0;
                    winner_d = WINNER_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            start_q  <= 1'b0;
            arm_q    <= 1'b0;
            press_q  <= 1'b0;
            state_q  <= ST_IDLE;
            run_q    <= 1'b0;
            serve_q  <= 1'b0;
            player_q <= '0;
            enemy_q  <= '0;
            winner_q <= WINNER_NONE;
        end else begin
            start_q  <= start_i;
            // A key held through reset must be seen released before it can count.
            arm_q    <= arm_q || !start_i;
            press_q  <= start_i && !start_q && arm_q;
            state_q  <= state_d;
            run_q    <= (state_d == ST_PLAY);
            serve_q  <= (state_d == ST_SERVE) && (state_q != ST_SERVE);
            player_q <= player_d;
            enemy_q  <= enemy_d;
            winner_q <= winner_d;
        end
    end

    assign run_o          = run_q;
    assign serve_o        = serve_q;
    assign player_score_o = player_q;
    assign enemy_score_o  = enemy_q;
    assign winner_o       = winner_q;
    assign state_o        = state_q;

endmodule
